// File: rtl/paddle_pkg.sv
// Shared types and constants for the Pong paddle position controller.
package paddle_pkg;

  // Per-player input source selection.
  typedef enum logic [2:0] {
    MODE_DIGITAL    = 3'd0,
    MODE_Y          = 3'd1,
    MODE_Y_INV      = 3'd2,
    MODE_X          = 3'd3,
    MODE_X_INV      = 3'd4,
    MODE_PADDLE     = 3'd5,
    MODE_PADDLE_INV = 3'd6,
    MODE_FIXED      = 3'd7
  } mode_e;

  // Default screen geometry of the Pong core.
  localparam int DEF_UGAP         = 23;
  localparam int DEF_LGAP         = 13;
  localparam int DEF_CENTER       = 114;
  localparam int DEF_ACCEL_FRAMES = 8;

  // Digital base step sizes selected by the speed input.
  localparam logic [3:0] STEP_SLOW = 4'd4;
  localparam logic [3:0] STEP_FAST = 4'd8;

  // Number of usable positions between the top and bottom margins.
  function automatic int span(input int ugap, input int lgap);
    return 256 - ugap - lgap;
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One player's paddle path: analog mapping, digital integrator with
// acceleration, frame latch, scanline counter and comparator output.
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int UGAP         = DEF_UGAP,
  parameter int LGAP         = DEF_LGAP,
  parameter int CENTER       = DEF_CENTER,
  parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       hsync_re,
  input  logic       vsync_re,
  input  logic       pad_trg_n,
  input  logic [3:0] base_step,
  input  logic [2:0] mode,
  input  logic       dig_up,
  input  logic       dig_down,
  input  logic [7:0] ana_x,
  input  logic [7:0] ana_y,
  input  logic [7:0] paddle,
  output logic       pad_out,
  output logic [7:0] pos_out
);

  localparam int         SPAN     = span(UGAP, LGAP);
  localparam logic [7:0] SPAN8    = 8'(SPAN);
  localparam logic [7:0] UGAP8    = 8'(UGAP);
  localparam logic [8:0] POS_MIN  = 9'(UGAP);
  localparam logic [8:0] POS_MAX  = 9'(255 - LGAP);
  localparam logic [7:0] CENTER8  = 8'(CENTER);
  localparam int         HOLD_W   = $clog2(ACCEL_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACCEL_FRAMES);

  mode_e             mode_in;
  mode_e             mode_q;
  logic [7:0]        v_sel;
  logic [15:0]       product;
  logic [7:0]        mapped_nxt;
  logic [7:0]        mapped_q;

  logic              up_only;
  logic              dn_only;
  logic              one_dir;
  logic              dir_change;
  logic              enter_digital;
  logic [4:0]        step;
  logic [8:0]        up_val;
  logic [8:0]        dn_val;
  logic [8:0]        pos_d_q;
  logic [8:0]        pos_d_nxt;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_nxt;
  logic              last_dn_q;
  logic              last_dn_nxt;
  logic [7:0]        target;
  logic [7:0]        pos_lat_q;
  logic [7:0]        cnt_q;

  assign mode_in = mode_e'(mode);

  // Select the analog source, convert signed axes to offset binary, scale into the play field.
  // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    v_sel = paddle;
    unique case (mode_in)
      MODE_Y, MODE_Y_INV: v_sel = {~ana_y[7], ana_y[6:0]};
      MODE_X, MODE_X_INV: v_sel = {~ana_x[7], ana_x[6:0]};
      default:            v_sel = paddle;
    endcase
    if (mode_in == MODE_Y_INV || mode_in == MODE_X_INV || mode_in == MODE_PADDLE_INV) begin
      v_sel = ~v_sel;
    end
    product    = 16'(v_sel) * 16'(SPAN8);
    mapped_nxt = UGAP8 + product[15:8];
  end

  // Register the mapped position and the mode; the mode register gives the Digital entry edge.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mapped_q <= '0;
      mode_q   <= MODE_DIGITAL;
    end else begin
      mapped_q <= mapped_nxt;
      mode_q   <= mode_in;
    end
  end

  assign up_only       = dig_up & ~dig_down;
  assign dn_only       = dig_down & ~dig_up;
  assign one_dir       = up_only | dn_only;
  assign dir_change    = one_dir && (hold_q != '0) && (dn_only != last_dn_q);
  assign enter_digital = (mode_in == MODE_DIGITAL) && (mode_q != MODE_DIGITAL);

  // Step size and clamped candidate positions; compares are widened so nothing wraps.
  always_comb begin
    step = {1'b0, base_step};
    if (hold_q >= HOLD_MAX && !dir_change) begin
      step = {base_step, 1'b0};
    end
    up_val = 9'(pos_d_q - 9'(step));
    if (10'(pos_d_q) < 10'(step) + 10'(POS_MIN)) begin
      up_val = POS_MIN;
    end
    dn_val = 9'(pos_d_q + 9'(step));
    if (10'(pos_d_q) + 10'(step) > 10'(POS_MAX)) begin
      dn_val = POS_MAX;
    end
  end

  // Next integrator state: bumpless load on Digital entry has priority over a frame step.
  always_comb begin
    pos_d_nxt   = pos_d_q;
    hold_nxt    = hold_q;
    last_dn_nxt = last_dn_q;
    if (enter_digital) begin
      pos_d_nxt = {1'b0, pos_lat_q};
    end else if (vsync_re) begin
      if (up_only) begin
        pos_d_nxt = up_val;
      end else if (dn_only) begin
        pos_d_nxt = dn_val;
      end
    end
    if (vsync_re) begin
      if (!one_dir || dir_change) begin
        hold_nxt = '0;
      end else if (hold_q < HOLD_MAX) begin
        hold_nxt = hold_q + 1'b1;
      end
      if (one_dir) begin
        last_dn_nxt = dn_only;
      end
    end
  end

  // Digital integrator state.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pos_d_q   <= 9'(CENTER);
      hold_q    <= '0;
      last_dn_q <= 1'b0;
    end else begin
      pos_d_q   <= pos_d_nxt;
      hold_q    <= hold_nxt;
      last_dn_q <= last_dn_nxt;
    end
  end

  // Frame target; Digital uses the next integrator value so a step shows on the same frame edge.
  always_comb begin
    target = mapped_q;
    unique case (mode_q)
      MODE_DIGITAL: target = pos_d_nxt[7:0];
      MODE_FIXED:   target = CENTER8;
      default:      target = mapped_q;
    endcase
  end

  // Latch the position once per frame so it never moves mid-frame.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pos_lat_q <= CENTER8;
    end else if (vsync_re) begin
      pos_lat_q <= target;
    end
  end

  // Scanline counter from the paddle trigger; clear wins over a line edge, saturates at 255.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!pad_trg_n) begin
      cnt_q <= '0;
    end else if (hsync_re && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Comparator pulse: high while the line count is above the paddle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pad_out <= 1'b0;
    end else begin
      pad_out <= (cnt_q < pos_lat_q);
    end
  end

  assign pos_out = pos_lat_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Multi-player paddle controller: shared sync edge detect and base step,
// one paddle_channel per player.
module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int UGAP         = DEF_UGAP,
  parameter int LGAP         = DEF_LGAP,
  parameter int CENTER       = DEF_CENTER,
  parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic                     pad_trg_n,
  input  logic                     speed,
  input  logic [3*NUM_PLAYERS-1:0] mode,
  input  logic [NUM_PLAYERS-1:0]   dig_up,
  input  logic [NUM_PLAYERS-1:0]   dig_down,
  input  logic [8*NUM_PLAYERS-1:0] ana_x,
  input  logic [8*NUM_PLAYERS-1:0] ana_y,
  input  logic [8*NUM_PLAYERS-1:0] paddle,
  output logic [NUM_PLAYERS-1:0]   pad_out,
  output logic [8*NUM_PLAYERS-1:0] pos_out
);

  logic       hsync_d;
  logic       vsync_d;
  logic       hsync_re;
  logic       vsync_re;
  logic [3:0] base_step;

  // One-cycle delay of the sync levels for rising-edge detection.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hsync_d <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      hsync_d <= hsync;
      vsync_d <= vsync;
    end
  end

  assign hsync_re  = hsync & ~hsync_d;
  assign vsync_re  = vsync & ~vsync_d;
  assign base_step = speed ? STEP_FAST : STEP_SLOW;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
    paddle_channel #(
      .UGAP         (UGAP),
      .LGAP         (LGAP),
      .CENTER       (CENTER),
      .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_ch (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .hsync_re  (hsync_re),
      .vsync_re  (vsync_re),
      .pad_trg_n (pad_trg_n),
      .base_step (base_step),
      .mode      (mode[3*i +: 3]),
      .dig_up    (dig_up[i]),
      .dig_down  (dig_down[i]),
      .ana_x     (ana_x[8*i +: 8]),
      .ana_y     (ana_y[8*i +: 8]),
      .paddle    (paddle[8*i +: 8]),
      .pad_out   (pad_out[i]),
      .pos_out   (pos_out[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed self-checking bench for paddle_ctrl with default parameters, two players.
module tb_paddle_ctrl;

  localparam int NP = 2;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            hsync;
  logic            vsync;
  logic            pad_trg_n;
  logic            speed;
  logic [3*NP-1:0] mode;
  logic [NP-1:0]   dig_up;
  logic [NP-1:0]   dig_down;
  logic [8*NP-1:0] ana_x;
  logic [8*NP-1:0] ana_y;
  logic [8*NP-1:0] paddle;
  logic [NP-1:0]   pad_out;
  logic [8*NP-1:0] pos_out;

  int n_checks = 0;
  int n_fail   = 0;

  paddle_ctrl #(.NUM_PLAYERS(NP)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .hsync     (hsync),
    .vsync     (vsync),
    .pad_trg_n (pad_trg_n),
    .speed     (speed),
    .mode      (mode),
    .dig_up    (dig_up),
    .dig_down  (dig_down),
    .ana_x     (ana_x),
    .ana_y     (ana_y),
    .paddle    (paddle),
    .pad_out   (pad_out),
    .pos_out   (pos_out)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One vsync pulse; the position is latched on the edge after vsync rises.
  task automatic frame();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic hpulse();
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_mode(input int ch, input logic [2:0] m);
    mode[3*ch +: 3] = m;
  endtask

  function automatic int pos(input int ch);
    return int'(pos_out[8*ch +: 8]);
  endfunction

  initial begin
    int exp_up[12];
    int seen_high;
    exp_up = '{110, 106, 102, 98, 94, 90, 86, 82, 74, 66, 58, 50};

    reset     = 1'b1;
    hsync     = 1'b0;
    vsync     = 1'b0;
    pad_trg_n = 1'b1;
    speed     = 1'b0;
    mode      = '0;
    dig_up    = '0;
    dig_down  = '0;
    ana_x     = '0;
    ana_y     = '0;
    paddle    = '0;

    // Reset state
    tick(); tick(); tick();
    check("pad_out_in_reset", int'(pad_out), 0);
    check("pos0_in_reset", pos(0), 114);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) frame();
    check("pos0_idle", pos(0), 114);
    check("pos1_idle", pos(1), 114);

    // Digital up with acceleration after 8 frames
    dig_up[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      frame();
      check($sformatf("up_accel_f%0d", i + 1), pos(0), exp_up[i]);
    end
    dig_up[0] = 1'b0;
    check("pos1_untouched", pos(1), 114);

    // Comparator pulse with pos_lat = 50
    pad_trg_n = 1'b0;
    tick(); tick();
    pad_trg_n = 1'b1;
    tick(); tick();
    check("pad0_after_trg", int'(pad_out[0]), 1);
    for (int k = 1; k <= 60; k++) begin
      hpulse();
      check($sformatf("pad0_line%0d", k), int'(pad_out[0]), (k < 50) ? 1 : 0);
    end
    seen_high = 0;
    for (int k = 0; k < 300; k++) begin
      hpulse();
      if (pad_out[0]) seen_high = 1;
    end
    check("pad0_no_reassert_after_sat", seen_high, 0);
    check("pad1_low_after_sat", int'(pad_out[1]), 0);

    // Down clamps at 242
    dig_down[0] = 1'b1;
    for (int i = 0; i < 30; i++) frame();
    check("down_clamp", pos(0), 242);
    dig_down[0] = 1'b0;
    frame();
    check("release_hold", pos(0), 242);

    // Up 10 frames, then both, then one up frame at base step
    dig_up[0] = 1'b1;
    frame();
    check("up_first_step", pos(0), 238);
    for (int i = 0; i < 9; i++) frame();
    check("up_10_frames", pos(0), 194);
    dig_down[0] = 1'b1;
    frame();
    check("both_no_move", pos(0), 194);
    dig_down[0] = 1'b0;
    frame();
    check("hold_reset_by_both", pos(0), 190);
    for (int i = 0; i < 40; i++) frame();
    check("up_clamp", pos(0), 23);
    dig_up[0] = 1'b0;
    frame();

    // Fast base step
    speed       = 1'b1;
    dig_down[0] = 1'b1;
    frame();
    check("speed1_step", pos(0), 31);
    dig_down[0] = 1'b0;
    speed       = 1'b0;
    frame();

    // Analog Y / Y-Inv on channel 0
    set_mode(0, 3'd1);
    ana_y[7:0] = 8'h80;
    tick();
    frame();
    check("y_min", pos(0), 23);
    ana_y[7:0] = 8'h7F;
    tick(); tick(); tick();
    check("y_midframe_hold", pos(0), 23);
    frame();
    check("y_max", pos(0), 242);
    set_mode(0, 3'd2);
    tick();
    frame();
    check("y_inv_max", pos(0), 23);

    // Analog X / X-Inv and fixed on channel 1
    set_mode(1, 3'd3);
    ana_x[15:8] = 8'h00;
    tick();
    frame();
    check("x_zero", pos(1), 133);
    set_mode(1, 3'd4);
    tick();
    frame();
    check("x_inv_zero", pos(1), 132);
    set_mode(1, 3'd7);
    tick();
    frame();
    check("fixed_center", pos(1), 114);

    // Bumpless switch coinciding with vsync_re and a held button
    set_mode(0, 3'd5);
    paddle[7:0] = 8'd200;
    tick();
    frame();
    check("paddle_200", pos(0), 194);
    set_mode(0, 3'd0);
    dig_down[0] = 1'b1;
    vsync       = 1'b1;
    tick();
    vsync       = 1'b0;
    dig_down[0] = 1'b0;
    tick(); tick();
    check("switch_same_vsync", pos(0), 194);
    frame();
    check("switch_no_step", pos(0), 194);

    // Bumpless switch outside vsync
    set_mode(0, 3'd6);
    tick();
    frame();
    check("paddle_inv_200", pos(0), 70);
    set_mode(0, 3'd0);
    tick(); tick();
    frame();
    check("switch_bumpless", pos(0), 70);

    // Asynchronous reset mid-frame
    dig_up[0] = 1'b1;
    frame();
    check("pre_reset_move", pos(0), 66);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_pos", pos(0), 114);
    check("async_reset_pad", int'(pad_out), 0);
    dig_up[0] = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
